nco_pipelined: RTL and testbench

//  Parametrised numerically controlled oscillator for the modulator DSP chain: a programmable-frequency

---
 rtl/nco_pipelined_pkg.sv | 44 ++++
 rtl/sine_quarter_lut.sv | 46 ++++
 rtl/nco_pipelined.sv | 180 ++++++++++++++++++
 tb/tb_nco_pipelined.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pipelined_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : nco_pipelined_pkg                                               |
// | Brief  : Shared types, LFSR constants and quadrant fold helper for the   |
// |          pipelined NCO.                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package nco_pipelined_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } nco_quadrant_t;

  // How a quarter-wave magnitude is turned into a full-cycle sample.
  typedef struct packed {
    logic negate;
    logic mirror;
  } nco_fold_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: taps at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Second half of the cycle is negated, odd quadrants read the table backwards.
  function automatic nco_fold_t quadrant_fold(input nco_quadrant_t q);
    nco_fold_t f;
    case (q)
      Q0:      f = '{negate: 1'b0, mirror: 1'b0};
      Q1:      f = '{negate: 1'b0, mirror: 1'b1};
      Q2:      f = '{negate: 1'b1, mirror: 1'b0};
      default: f = '{negate: 1'b1, mirror: 1'b1};
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : sine_quarter_lut                                                |
// | Brief  : Dual-read registered quarter-wave sine ROM. Entry k holds       |
// |          round(A*sin(2*pi*(k+0.5)/2**LUT_AW)), A = 2**(OUT_W-1)-1.        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module sine_quarter_lut #(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 18
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [LUT_AW-3:0] addr_a_i,
  input  logic [LUT_AW-3:0] addr_b_i,
  output logic [OUT_W-2:0]  data_a_o,
  output logic [OUT_W-2:0]  data_b_o
);

  localparam int  DEPTH  = 2 ** (LUT_AW - 2);
  localparam real AMP    = real'(2 ** (OUT_W - 1) - 1);
  localparam real TWO_PI = 6.283185307179586;

  logic [OUT_W-2:0] w_rom [DEPTH];

  // Table contents are elaboration-time constants; the half-step offset keeps
  // the quarter symmetric so mirroring needs no extra entry.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real ANG = TWO_PI * (real'(k) + 0.5) / real'(2 ** LUT_AW);
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign w_rom[k] = VAL[OUT_W-2:0];
  end

  // Both ports read in the same cycle; outputs are registered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_a_o <= '0;
      data_b_o <= '0;
    end else begin
      data_a_o <= w_rom[addr_a_i];
      data_b_o <= w_rom[addr_b_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/nco_pipelined.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : nco_pipelined                                                   |
// | Brief  : Phase accumulator NCO with offset, coherent frequency update,   |
// |          sync clear, optional LFSR dither and quarter-wave I/Q lookup.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module nco_pipelined
  import nco_pipelined_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int LUT_AW    = 10,
  parameter int OUT_W     = 18,
  parameter int DITHER_EN = 1,
  parameter int WRAP_UPD  = 1
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic                    ipEnable,
  input  logic                    ipSync,
  input  logic                    ipFreqValid,
  input  logic [ACC_W-1:0]        ipFrequency,
  output logic                    opFreqReady,
  input  logic [ACC_W-1:0]        ipPhaseOffset,
  output logic signed [OUT_W-1:0] opI,
  output logic signed [OUT_W-1:0] opQ,
  output logic                    opValid
);

  localparam int FRAC_W = ACC_W - LUT_AW;
  localparam int IDX_W  = LUT_AW - 2;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic [ACC_W-1:0] staged_q, staged_d;
  logic             pending_q, pending_d;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  assign w_sum       = {1'b0, acc_q} + {1'b0, active_q};
  assign w_carry     = ipEnable & w_sum[ACC_W];
  assign opFreqReady = ~pending_q;

  // Accumulator advance and single-entry frequency staging. A staged word is
  // applied on sync, on the next cycle (immediate mode) or on the carry edge
  // (wrap mode), so the new step is first used the cycle after the load.
  always_comb begin
    acc_d     = acc_q;
    active_d  = active_q;
    staged_d  = staged_q;
    pending_d = pending_q;
    if (ipSync) begin
      acc_d = '0;
    end else if (ipEnable) begin
      acc_d = w_sum[ACC_W-1:0];
    end
    if (pending_q && (ipSync || (WRAP_UPD == 0) || w_carry)) begin
      active_d  = staged_q;
      pending_d = 1'b0;
    end else if (!pending_q && ipFreqValid) begin
      staged_d  = ipFrequency;
      pending_d = 1'b1;
    end
  end

  // Accumulator and frequency state registers.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      acc_q     <= '0;
      active_q  <= '0;
      staged_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      active_q  <= active_d;
      staged_q  <= staged_d;
      pending_q <= pending_d;
    end
  end

  logic [ACC_W-1:0] w_dither;

  if (DITHER_EN != 0) begin : g_dither
    localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;
    logic [15:0] lfsr_q, lfsr_d;

    // The LFSR only moves when a sample is issued.
    always_comb lfsr_d = ipEnable ? lfsr_step(lfsr_q) : lfsr_q;

    // LFSR state register.
    always_ff @(posedge ipClk or negedge ipReset) begin
      if (!ipReset) lfsr_q <= LFSR_SEED;
      else          lfsr_q <= lfsr_d;
    end

    // Dither sits directly below the LUT address bits.
    assign w_dither = ACC_W'(lfsr_q[DITH_W-1:0]) << (FRAC_W - DITH_W);
  end else begin : g_no_dither
    assign w_dither = '0;
  end

  // S1: offset + dither, only the LUT phase bits are kept.
  logic [LUT_AW-1:0] w_phase;
  logic [FRAC_W-1:0] w_frac_unused;
  logic [LUT_AW-1:0] phase_q;
  logic              v1_q;

  assign {w_phase, w_frac_unused} = acc_q + ipPhaseOffset + w_dither;

  // S2: quadrant decode. Cosine is sine a quarter cycle ahead.
  nco_quadrant_t     w_quad_s, w_quad_c;
  nco_fold_t         w_fold_s, w_fold_c;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  addr_s_q, addr_c_q;
  logic              neg_s2_q, neg_c2_q, v2_q;

  assign w_quad_s = nco_quadrant_t'(phase_q[LUT_AW-1 -: 2]);
  assign w_quad_c = nco_quadrant_t'(phase_q[LUT_AW-1 -: 2] + 2'd1);
  assign w_idx    = phase_q[IDX_W-1:0];
  assign w_fold_s = quadrant_fold(w_quad_s);
  assign w_fold_c = quadrant_fold(w_quad_c);

  // S3: ROM read; sign flags travel alongside.
  logic [OUT_W-2:0] w_rom_s, w_rom_c;
  logic             neg_s3_q, neg_c3_q, v3_q;

  sine_quarter_lut #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_lut (
    .clk_i    (ipClk),
    .rst_n_i  (ipReset),
    .addr_a_i (addr_s_q),
    .addr_b_i (addr_c_q),
    .data_a_o (w_rom_s),
    .data_b_o (w_rom_c)
  );

  // S4: magnitudes fit in OUT_W-1 bits so negation cannot overflow.
  logic signed [OUT_W-1:0] w_mag_s, w_mag_c;
  assign w_mag_s = $signed({1'b0, w_rom_s});
  assign w_mag_c = $signed({1'b0, w_rom_c});

  // Free-running pipeline; outputs only update when a valid sample arrives.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      phase_q  <= '0;
      v1_q     <= 1'b0;
      addr_s_q <= '0;
      addr_c_q <= '0;
      neg_s2_q <= 1'b0;
      neg_c2_q <= 1'b0;
      v2_q     <= 1'b0;
      neg_s3_q <= 1'b0;
      neg_c3_q <= 1'b0;
      v3_q     <= 1'b0;
      opI      <= '0;
      opQ      <= '0;
      opValid  <= 1'b0;
    end else begin
      phase_q  <= w_phase;
      v1_q     <= ipEnable;
      addr_s_q <= w_fold_s.mirror ? ~w_idx : w_idx;
      addr_c_q <= w_fold_c.mirror ? ~w_idx : w_idx;
      neg_s2_q <= w_fold_s.negate;
      neg_c2_q <= w_fold_c.negate;
      v2_q     <= v1_q;
      neg_s3_q <= neg_s2_q;
      neg_c3_q <= neg_c2_q;
      v3_q     <= v2_q;
      if (v3_q) begin
        opI <= neg_s3_q ? -w_mag_s : w_mag_s;
        opQ <= neg_c3_q ? -w_mag_c : w_mag_c;
      end
      opValid  <= v3_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nco_pipelined.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_nco_pipelined                                                |
// | Brief  : Self-checking bench: three NCO instances (immediate update,     |
// |          wrap update, immediate update with dither) on shared stimulus.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_nco_pipelined;

  localparam int NDUT = 3;
  localparam int AMP  = 131071;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, sync, fv;
  logic [31:0] freq, off;
  logic        rdy [NDUT];
  logic        vld [NDUT];
  logic signed [17:0] oi [NDUT];
  logic signed [17:0] oq [NDUT];

  always #5 clk = ~clk;

  // 0: immediate update, 1: wrap update, 2: immediate update + dither
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    nco_pipelined #(
      .ACC_W     (32),
      .LUT_AW    (10),
      .OUT_W     (18),
      .DITHER_EN ((g == 2) ? 1 : 0),
      .WRAP_UPD  ((g == 1) ? 1 : 0)
    ) u_dut (
      .ipClk         (clk),
      .ipReset       (rst_n),
      .ipEnable      (en),
      .ipSync        (sync),
      .ipFreqValid   (fv),
      .ipFrequency   (freq),
      .opFreqReady   (rdy[g]),
      .ipPhaseOffset (off),
      .opI           (oi[g]),
      .opQ           (oq[g]),
      .opValid       (vld[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int lut [256];

  task automatic cmp(input string name, input int n,
                     input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, n, got, exp, $time);
    end
  endtask

  // Full-cycle sine of a 10-bit phase built from the quarter table.
  function automatic int ref_sin(input int p);
    int q, idx, mag;
    q   = (p >> 8) & 3;
    idx = p & 255;
    mag = (q % 2 == 1) ? lut[255 - idx] : lut[idx];
    return (q >= 2) ? -mag : mag;
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NDUT-1:0]       v;
    logic [NDUT-1:0][31:0] si;
    logic [NDUT-1:0][31:0] sq;
  } samp_t;

  logic [31:0] m_acc [NDUT];
  logic [31:0] m_act [NDUT];
  logic [31:0] m_stg [NDUT];
  bit          m_pend[NDUT];
  logic [15:0] m_lfsr[NDUT];
  int          exp_i [NDUT];
  int          exp_q [NDUT];
  bit          exp_v [NDUT];
  samp_t       hist[$];

  function automatic bit is_wrap(input int n); return n == 1; endfunction
  function automatic bit is_dith(input int n); return n == 2; endfunction

  task automatic model_reset();
    for (int n = 0; n < NDUT; n++) begin
      m_acc[n] = '0; m_act[n] = '0; m_stg[n] = '0; m_pend[n] = 1'b0;
      m_lfsr[n] = 16'hACE1;
      exp_i[n] = 0; exp_q[n] = 0; exp_v[n] = 1'b0;
    end
    hist.delete();
  endtask

  // One clock edge: the sample issued now shows up at the outputs three edges later.
  task automatic model_step();
    samp_t s;
    logic [31:0] p32;
    logic [32:0] sum;
    int ph;
    bit carry, apply;
    s = '0;
    for (int n = 0; n < NDUT; n++) begin
      p32 = m_acc[n] + off + (is_dith(n) ? ({16'h0, m_lfsr[n]} << 6) : 32'h0);
      ph  = int'(p32[31:22]);
      s.v[n]  = en;
      s.si[n] = ref_sin(ph);
      s.sq[n] = ref_sin((ph + 256) % 1024);
      if (is_dith(n) && en)
        m_lfsr[n] = {m_lfsr[n][0] ^ m_lfsr[n][2] ^ m_lfsr[n][3] ^ m_lfsr[n][5], m_lfsr[n][15:1]};
      sum   = {1'b0, m_acc[n]} + {1'b0, m_act[n]};
      carry = en && sum[32];
      apply = m_pend[n] && (sync || !is_wrap(n) || carry);
      if (sync) m_acc[n] = '0;
      else if (en) m_acc[n] = sum[31:0];
      if (apply) begin
        m_act[n] = m_stg[n]; m_pend[n] = 1'b0;
      end else if (!m_pend[n] && fv) begin
        m_stg[n] = freq; m_pend[n] = 1'b1;
      end
    end
    hist.push_back(s);
    if (hist.size() > 3) begin
      s = hist.pop_front();
      for (int n = 0; n < NDUT; n++) begin
        exp_v[n] = s.v[n];
        if (s.v[n]) begin
          exp_i[n] = int'(s.si[n]);
          exp_q[n] = int'(s.sq[n]);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int n = 0; n < NDUT; n++) begin
      cmp("valid", n, 32'(vld[n]), 32'(exp_v[n]));
      cmp("sin",   n, oi[n], exp_i[n]);
      cmp("cos",   n, oq[n], exp_q[n]);
      cmp("ready", n, 32'(rdy[n]), 32'(!m_pend[n]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle: outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int n = 0; n < NDUT; n++) begin
      cmp("rst_sin",   n, oi[n], 0);
      cmp("rst_cos",   n, oq[n], 0);
      cmp("rst_valid", n, 32'(vld[n]), 0);
      cmp("rst_ready", n, 32'(rdy[n]), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Quarter-cycle step on the immediate-update instance after a sync.
  task automatic scen_quarter_step();
    int ei [4];
    int eq [4];
    ei = '{lut[0], lut[255], -lut[0], -lut[255]};
    eq = '{lut[255], -lut[0], -lut[255], lut[0]};
    off = '0; en = 1'b1; fv = 1'b1; freq = 32'h4000_0000;
    tick();
    fv = 1'b0;
    repeat (4) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      cmp("s1_sin", 0, oi[0], ei[k]);
      cmp("s1_cos", 0, oq[0], eq[k]);
    end
  endtask

  typedef struct {
    logic [31:0] off;
    int          ei;
    int          eq;
  } vec_t;
  vec_t tab [6];

  initial begin
    int cnt;
    int mag;
    for (int k = 0; k < 256; k++)
      lut[k] = $rtoi(131071.0 * $sin(2.0 * 3.141592653589793 * (real'(k) + 0.5) / 1024.0) + 0.5);
    tab[0] = '{32'h0000_0000,  lut[0],    lut[255]};
    tab[1] = '{32'h4000_0000,  lut[255], -lut[0]};
    tab[2] = '{32'h8000_0000, -lut[0],   -lut[255]};
    tab[3] = '{32'hC000_0000, -lut[255],  lut[0]};
    tab[4] = '{32'h0040_0000,  lut[1],    lut[254]};
    tab[5] = '{32'hFFC0_0000, -lut[0],    lut[255]};

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; fv = 1'b0; freq = '0; off = '0;
    model_reset();
    #2;
    do_reset();

    // Static phase offsets with zero frequency.
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      off = tab[i].off;
      repeat (3) tick();
      if (i > 0) cmp("ofs_hold", 0, oi[0], tab[i-1].ei);
      tick();
      for (int n = 0; n < NDUT; n++) begin
        cmp("ofs_sin", n, oi[n], tab[i].ei);
        cmp("ofs_cos", n, oq[n], tab[i].eq);
      end
    end

    do_reset();
    scen_quarter_step();

    // Wrap-coherent update on instance 1.
    do_reset();
    off = '0; en = 1'b0; fv = 1'b1; freq = 32'h8000_0000;
    tick();
    fv = 1'b0; sync = 1'b1;
    tick();
    sync = 1'b0;
    cmp("s2_loaded", 1, 32'(rdy[1]), 1);
    en = 1'b1;
    repeat (2) tick();
    fv = 1'b1; freq = 32'h4000_0000;
    tick();
    cmp("s2_pending", 1, 32'(rdy[1]), 0);
    freq = 32'h1234_5678;
    cnt = 0;
    while (!rdy[1] && cnt < 4) begin
      tick();
      fv = 1'b0;
      cnt++;
    end
    fv = 1'b0;
    cmp("s2_ready_lat", 1, cnt, 1);
    repeat (10) tick();

    // Sync with a pending word applies it at once.
    fv = 1'b1; freq = 32'h2000_0000;
    tick();
    fv = 1'b0;
    cmp("s4_pending", 1, 32'(rdy[1]), 0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    cmp("s4_sync_apply", 1, 32'(rdy[1]), 1);
    repeat (4) tick();
    cmp("s4_zero_phase", 1, oi[1], lut[0]);
    tick();
    cmp("s4_new_step", 1, oi[1], lut[128]);

    // Reset in the middle of activity, then restart.
    repeat (5) tick();
    do_reset();
    scen_quarter_step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 7) != 0);
      sync = ($urandom_range(0, 63) == 0);
      fv   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       freq = $urandom;
        1:       freq = 32'h4000_0000;
        2:       freq = $urandom >> $urandom_range(4, 16);
        default: freq = 32'h8000_0000;
      endcase
      if ($urandom_range(0, 31) == 0) off = $urandom;
      if (c % 700 == 699) do_reset();
      else tick();
    end

    // Long dithered run: amplitude must stay within the table range.
    do_reset();
    en = 1'b1; sync = 1'b0; off = '0; fv = 1'b1; freq = 32'h0010_0000;
    tick();
    fv = 1'b0;
    for (int c = 0; c < 65536; c++) begin
      tick();
      mag = (oi[2] < 0) ? -int'(oi[2]) : int'(oi[2]);
      cmp("dith_bound_i", 2, 32'(mag <= AMP), 1);
      mag = (oq[2] < 0) ? -int'(oq[2]) : int'(oq[2]);
      cmp("dith_bound_q", 2, 32'(mag <= AMP), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
